// File: rtl/osc_pkg.sv
// rtl/osc_pkg.sv - shared types and defaults for the oscillator update scheduler
package osc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_OSC_DEF    = 8;
    localparam int POT_W_DEF      = 8;
    localparam int THRESH_RST_DEF = 128;
    localparam int RES_TMO_DEF    = 15;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/osc_state_regfile.sv
// rtl/osc_state_regfile.sv - per-oscillator potential and threshold storage
module osc_state_regfile
    import osc_pkg::*;
#(
    parameter int               NUM_OSC    = NUM_OSC_DEF,
    parameter int               POT_W      = POT_W_DEF,
    parameter logic [POT_W-1:0] THRESH_RST = POT_W'(THRESH_RST_DEF),
    parameter int               IDX_W      = idx_w(NUM_OSC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sch_we,
    input  logic [IDX_W-1:0] sch_idx,
    input  logic [POT_W-1:0] sch_pot,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [POT_W-1:0] cfg_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [POT_W-1:0] rd_pot,
    output logic [POT_W-1:0] rd_thresh
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [POT_W-1:0] pot_mem [DEPTH];
    logic [POT_W-1:0] thr_mem [DEPTH];
    logic             cfg_in_range;

    // Extra bit keeps the range test meaningful when NUM_OSC is a power of two
    assign cfg_in_range = {1'b0, cfg_addr} < (IDX_W+1)'(NUM_OSC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pot_mem[i] <= '0;
                thr_mem[i] <= THRESH_RST;
            end
        end else begin
            if (sch_we) begin
                pot_mem[sch_idx] <= sch_pot;
            end
            if (cfg_we && cfg_in_range) begin
                thr_mem[cfg_addr] <= cfg_data;
            end
        end
    end

    assign rd_pot    = pot_mem[rd_idx];
    assign rd_thresh = thr_mem[rd_idx];

endmodule

// File: rtl/osc_update_scheduler.sv
// rtl/osc_update_scheduler.sv - sweeps all oscillators through one shared update datapath per tick
module osc_update_scheduler
    import osc_pkg::*;
#(
    parameter int               NUM_OSC    = NUM_OSC_DEF,
    parameter int               POT_W      = POT_W_DEF,
    parameter logic [POT_W-1:0] THRESH_RST = POT_W'(THRESH_RST_DEF),
    parameter int               RES_TMO    = RES_TMO_DEF,
    localparam int              IDX_W      = idx_w(NUM_OSC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               tick,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [POT_W-1:0]   cfg_data,
    output logic               upd_valid,
    input  logic               upd_ready,
    output logic [IDX_W-1:0]   upd_idx,
    output logic [POT_W-1:0]   upd_pot,
    output logic [POT_W-1:0]   upd_thresh,
    input  logic               res_valid,
    input  logic [POT_W-1:0]   res_pot,
    input  logic               res_spike,
    output logic [NUM_OSC-1:0] spike_vec,
    output logic               spike_pulse,
    output logic               busy,
    output logic               overrun,
    output logic               res_timeout
);

    localparam int TMO_W = $clog2(RES_TMO + 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [NUM_OSC-1:0] acc;
    logic [POT_W-1:0]   thresh_lat;
    logic [POT_W-1:0]   rd_pot, rd_thresh;
    logic               last_idx, tmo_hit, wait_adv, sch_we;

    assign last_idx = (idx == IDX_W'(NUM_OSC - 1));
    assign tmo_hit  = (tmo_cnt == TMO_W'(RES_TMO - 1));
    assign wait_adv = (state == WAIT) && (res_valid || tmo_hit);
    assign sch_we   = (state == WAIT) && res_valid;

    // Reading at idx_nxt lets the threshold be latched on the edge that enters ISSUE;
    // inside ISSUE idx_nxt equals idx, so upd_pot still reflects the current index.
    osc_state_regfile #(
        .NUM_OSC    (NUM_OSC),
        .POT_W      (POT_W),
        .THRESH_RST (THRESH_RST),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .sch_we    (sch_we),
        .sch_idx   (idx),
        .sch_pot   (res_pot),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .rd_idx    (idx_nxt),
        .rd_pot    (rd_pot),
        .rd_thresh (rd_thresh)
    );

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        upd_valid  = 1'b0;
        upd_idx    = idx;
        upd_pot    = '0;
        upd_thresh = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (tick && enable) begin
                    state_nxt = ISSUE;
                    idx_nxt   = '0;
                end
            end
            ISSUE: begin
                upd_valid  = 1'b1;
                upd_pot    = rd_pot;
                upd_thresh = thresh_lat;
                if (upd_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_adv) begin
                    if (last_idx) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ISSUE;
                        idx_nxt   = idx + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            tmo_cnt     <= '0;
            acc         <= '0;
            thresh_lat  <= '0;
            spike_vec   <= '0;
            spike_pulse <= 1'b0;
            overrun     <= 1'b0;
            res_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            spike_pulse <= 1'b0;
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end
            if (state_nxt == ISSUE && state != ISSUE) begin
                thresh_lat <= rd_thresh;
            end
            case (state)
                IDLE: begin
                    if (tick && enable) begin
                        acc <= '0;
                    end
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                end
                WAIT: begin
                    if (res_valid) begin
                        acc[idx] <= res_spike;
                    end else if (tmo_hit) begin
                        acc[idx]    <= 1'b0;
                        res_timeout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                DONE: begin
                    spike_vec   <= acc;
                    spike_pulse <= |acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_osc_update_scheduler.sv
// tb/tb_osc_update_scheduler.sv - directed self-checking bench for osc_update_scheduler
module tb_osc_update_scheduler;

    logic       clk = 1'b0;
    logic       rst, enable, tick, cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       upd_valid, upd_ready;
    logic [2:0] upd_idx;
    logic [7:0] upd_pot, upd_thresh;
    logic       res_valid, res_spike;
    logic [7:0] res_pot;
    logic [7:0] spike_vec;
    logic       spike_pulse, busy, overrun, res_timeout;

    int n_vec = 0;
    int n_err = 0;

    logic       ready_en, stall_on, drop_on;
    logic [2:0] stall_idx, drop_idx;
    logic [7:0] pot_ofs, spike_mask;

    // Datapath stand-in: immediate ready/result unless a stall or drop is armed
    assign upd_ready = ready_en && !(stall_on && upd_idx == stall_idx);
    assign res_valid = !(drop_on && upd_idx == drop_idx);
    assign res_pot   = {5'd0, upd_idx} + pot_ofs;
    assign res_spike = spike_mask[upd_idx];

    always #5 clk = ~clk;

    osc_update_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .tick        (tick),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_idx     (upd_idx),
        .upd_pot     (upd_pot),
        .upd_thresh  (upd_thresh),
        .res_valid   (res_valid),
        .res_pot     (res_pot),
        .res_spike   (res_spike),
        .spike_vec   (spike_vec),
        .spike_pulse (spike_pulse),
        .busy        (busy),
        .overrun     (overrun),
        .res_timeout (res_timeout)
    );

    int         hs_n;
    int         pulse_n;
    logic [2:0] hs_idx [16];
    logic [7:0] hs_pot [16];
    logic [7:0] hs_thr [16];

    always @(posedge clk) begin
        if (upd_valid && upd_ready && hs_n < 16) begin
            hs_idx[hs_n] = upd_idx;
            hs_pot[hs_n] = upd_pot;
            hs_thr[hs_n] = upd_thresh;
            hs_n = hs_n + 1;
        end
        if (spike_pulse) pulse_n = pulse_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (busy && c < 400) begin
            @(negedge clk);
            c++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_issue(input logic [2:0] i, input string tag);
        int c = 0;
        while (!(upd_valid && upd_idx == i) && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk(tag, {31'd0, upd_valid && upd_idx == i}, 32'd1);
    endtask

    function automatic logic [31:0] out_word();
        return {upd_valid, upd_idx, upd_pot, upd_thresh, spike_vec,
                spike_pulse, busy, overrun, res_timeout};
    endfunction

    function automatic logic [23:0] idx_pack();
        logic [23:0] v = '0;
        for (int i = 0; i < 8; i++) v[3*i +: 3] = hs_idx[i];
        return v;
    endfunction

    function automatic logic [63:0] pot_pack();
        logic [63:0] v = '0;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = hs_pot[i];
        return v;
    endfunction

    function automatic logic all_thr(input logic [7:0] t);
        logic ok = 1'b1;
        for (int i = 0; i < 8; i++) if (hs_thr[i] !== t) ok = 1'b0;
        return ok;
    endfunction

    initial begin
        int   c;
        logic stable;
        rst = 1'b1; enable = 1'b1; tick = 1'b0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_data = '0;
        ready_en = 1'b1; stall_on = 1'b0; drop_on = 1'b0;
        stall_idx = '0; drop_idx = '0; pot_ofs = 8'd1; spike_mask = 8'h08;
        hs_n = 0; pulse_n = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", out_word(), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic sweep, latency and spike vector
        hs_n = 0; pulse_n = 0;
        do_tick();
        chk("t1_valid_latency", {31'd0, upd_valid}, 32'd1);
        chk("t1_first_thresh", {24'd0, upd_thresh}, 32'd128);
        c = 0;
        while (!spike_pulse && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("t1_pulse_cycle", c, 32'd17);
        chk("t1_spike_vec", {24'd0, spike_vec}, 32'h08);
        chk("t1_hs_count", hs_n, 32'd8);
        chk("t1_hs_order", {8'd0, idx_pack()}, 32'h00FAC688);
        @(negedge clk);
        chk("t1_pulse_once", {30'd0, spike_pulse, busy}, 32'd0);
        chk("t1_pulse_count", pulse_n, 32'd1);

        // 2: writeback visible on the next sweep
        hs_n = 0;
        do_tick();
        wait_idle("t2_idle");
        chk("t2_pot_lo", pot_pack()[31:0], 32'h04030201);
        chk("t2_pot_hi", pot_pack()[63:32], 32'h08070605);
        chk("t2_thr", {31'd0, all_thr(8'd128)}, 32'd1);

        // 3: backpressure at idx 2
        stall_on = 1'b1; stall_idx = 3'd2; hs_n = 0;
        do_tick();
        wait_issue(3'd2, "t3_reach2");
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (!(upd_valid && upd_idx == 3'd2 && upd_pot == 8'd3 &&
                  upd_thresh == 8'd128 && hs_n == 2)) stable = 1'b0;
            @(negedge clk);
        end
        chk("t3_stable", {31'd0, stable}, 32'd1);
        stall_on = 1'b0;
        wait_idle("t3_idle");
        chk("t3_hs_count", hs_n, 32'd8);
        chk("t3_hs_order", {8'd0, idx_pack()}, 32'h00FAC688);

        // 4: tick while disabled vs tick while busy
        enable = 1'b0; hs_n = 0;
        do_tick();
        repeat (3) @(negedge clk);
        chk("t4_disabled", {29'd0, busy, overrun, 1'b0}, 32'd0);
        chk("t4_disabled_hs", hs_n, 32'd0);
        enable = 1'b1;
        do_tick();
        repeat (3) @(negedge clk);
        do_tick();
        chk("t4_overrun", {31'd0, overrun}, 32'd1);
        wait_idle("t4_idle");
        repeat (3) @(negedge clk);
        chk("t4_hs_count", hs_n, 32'd8);
        chk("t4_no_restart", {31'd0, busy}, 32'd0);

        // 5: missing result at idx 5
        chk("t5_tmo_clear", {31'd0, res_timeout}, 32'd0);
        drop_on = 1'b1; drop_idx = 3'd5; pot_ofs = 8'd10; spike_mask = 8'h28; hs_n = 0;
        do_tick();
        c = 0;
        while (!(busy && !upd_valid && upd_idx == 3'd5) && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("t5_reach_wait5", {31'd0, busy && !upd_valid && upd_idx == 3'd5}, 32'd1);
        c = 0;
        while (!res_timeout && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("t5_tmo_cycle", c, 32'd15);
        wait_idle("t5_idle");
        chk("t5_spike_vec", {24'd0, spike_vec}, 32'h08);
        chk("t5_hs_count", hs_n, 32'd8);
        drop_on = 1'b0;

        // 6: threshold write mid-handshake, then reset mid-sweep
        stall_on = 1'b1; stall_idx = 3'd4; pot_ofs = 8'd20; spike_mask = 8'h08; hs_n = 0;
        do_tick();
        wait_issue(3'd4, "t6_reach4");
        cfg_we = 1'b1; cfg_addr = 3'd4; cfg_data = 8'd200;
        @(negedge clk);
        cfg_we = 1'b0;
        chk("t6_thr_held", {24'd0, upd_thresh}, 32'd128);
        stall_on = 1'b0;
        wait_idle("t6_idle_a");
        chk("t6_thr4_old", {24'd0, hs_thr[4]}, 32'd128);
        chk("t6_pot5_kept", {24'd0, hs_pot[5]}, 32'd6);
        chk("t6_pot4", {24'd0, hs_pot[4]}, 32'd14);
        hs_n = 0;
        do_tick();
        wait_idle("t6_idle_b");
        chk("t6_thr4_new", {24'd0, hs_thr[4]}, 32'd200);
        chk("t6_thr3", {24'd0, hs_thr[3]}, 32'd128);
        chk("t6_pot5_new", {24'd0, hs_pot[5]}, 32'd25);
        chk("t6_sticky", {30'd0, overrun, res_timeout}, 32'd3);
        do_tick();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_outputs", out_word(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        hs_n = 0; spike_mask = 8'h00;
        do_tick();
        wait_idle("t6_idle_c");
        chk("t6_rst_thr", {31'd0, all_thr(8'd128)}, 32'd1);
        chk("t6_rst_pot_lo", pot_pack()[31:0], 32'd0);
        chk("t6_rst_pot_hi", pot_pack()[63:32], 32'd0);
        chk("t6_rst_hs_count", hs_n, 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
